program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter CNTR_WIDTH, default 8: width of the program counter and of every stored return address.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries; SHALL be a power of two of at least 2.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port halt  input  1: when 1, the PC holds, overriding sequential increment only.
REQ-006 Port jmp  input  1: jump request from the instruction decoder.
REQ-007 Port cal_f  input  1: call qualifier, meaningful only with jmp=1.
REQ-008 Port ret_f  input  1: return qualifier, meaningful only with jmp=1.
REQ-009 Port rst_f  input  1: decoder soft-reset flag, active-low, synchronous.
REQ-010 Port jmp_addr  input  CNTR_WIDTH: jump or call target.
REQ-011 Port pc  output  CNTR_WIDTH: registered instruction-ROM address.
REQ-012 Port stk_cnt  output  $clog2(STACK_DEPTH)+1: number of valid stack entries, 0..STACK_DEPTH.
REQ-013 Port err_ovf  output  1: sticky call-on-full flag.
REQ-014 Port err_unf  output  1: sticky return-on-empty flag.

Function
REQ-015 All outputs SHALL be registered; pc SHALL change only on a rising clk edge, one cycle after the decoder outputs that caused the change.
REQ-016 Next-state priority per edge SHALL be: rst_f=0, then jmp&cal_f, then jmp&ret_f, then jmp, then halt, then increment.
REQ-017 rst_f=0 SHALL set pc=0 and stk_cnt=0, leaving err flags unchanged.
REQ-018 A call (jmp=1, cal_f=1) SHALL push pc+1 (mod 2^CNTR_WIDTH), increment stk_cnt, and set pc=jmp_addr.
REQ-019 A return (jmp=1, ret_f=1, cal_f=0) SHALL set pc to the top entry and decrement stk_cnt.
REQ-020 cal_f=1 together with ret_f=1 SHALL be treated as a call.
REQ-021 A plain jump (jmp=1, cal_f=0, ret_f=0) SHALL set pc=jmp_addr without touching the stack.
REQ-022 cal_f or ret_f with jmp=0 SHALL be ignored.
REQ-023 halt=1 with no jump SHALL hold pc; a jump, call, return or soft reset SHALL still take effect while halt=1.
REQ-024 Otherwise pc SHALL increment by 1, wrapping from 2^CNTR_WIDTH-1 to 0.
REQ-025 Stack storage SHALL be LIFO and addressed by stk_cnt; entries above stk_cnt are don't-care and SHALL NOT be cleared.

Reset
REQ-026 rst=0 SHALL immediately force pc=0, stk_cnt=0, err_ovf=0 and err_unf=0, independent of clk.
REQ-027 Reset asserted during a call or return SHALL discard that operation completely.
REQ-028 Release of rst SHALL take effect at the first rising clk edge after deassertion, with pc=0 presented throughout.

Configuration
REQ-029 Macro STACK_GUARD_EN SHALL select stack-boundary protection.
REQ-030 With STACK_GUARD_EN defined, a call at stk_cnt=STACK_DEPTH SHALL hold pc, leave the stack unchanged, and set err_ovf.
REQ-031 With STACK_GUARD_EN defined, a return at stk_cnt=0 SHALL hold pc and set err_unf.
REQ-032 With STACK_GUARD_EN defined, both flags SHALL stay set until rst=0.
REQ-033 Without STACK_GUARD_EN, the write index SHALL wrap modulo STACK_DEPTH so that a call on full overwrites the oldest entry.
REQ-034 Without STACK_GUARD_EN, stk_cnt SHALL saturate at STACK_DEPTH on overflow.
REQ-035 Without STACK_GUARD_EN, a return on empty SHALL load the entry at index STACK_DEPTH-1 and leave stk_cnt at 0.
REQ-036 Without STACK_GUARD_EN, err_ovf and err_unf SHALL be tied to 0.

Verification (CNTR_WIDTH=8, STACK_DEPTH=4)
REQ-037 Release reset, idle 5 cycles -> pc steps 0,1,2,3,4,5; stk_cnt=0.
REQ-038 At pc=0x10, call 0x40, then 3 idle cycles, then return -> pc sequence 0x40,0x41,0x42,0x43,0x11; stk_cnt goes 1 then 0.
REQ-039 pc=0xFF with no jump -> pc=0x00 on the next edge; at pc=0x20, jmp=1 with halt=1 and jmp_addr=0x80 -> pc=0x80.
REQ-040 Guarded build: 5 nested calls -> the 5th holds pc, err_ovf=1, stk_cnt=4; then 5 returns -> the 5th holds pc and err_unf=1.
REQ-041 Assert rst_f=0 with stk_cnt=2 -> pc=0 and stk_cnt=0 next edge; assert rst=0 mid-cycle -> pc=0 with no clock edge.

Source files
------------

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with call/return address stack
//
// Purpose:
//   Registered instruction-ROM address generator. Each rising clk edge selects
//   one of: soft reset, call, return, jump, hold or increment. Calls push the
//   return address (pc+1) onto a small LIFO stack, and returns pop it.
//
// Configuration macro:
//   STACK_GUARD_EN - when defined, a call on a full stack or a return on an
//                    empty stack is refused. The PC holds and a sticky error
//                    flag is set. When undefined, the stack index wraps and
//                    the error flags are tied to 0.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   halt     in   hold pc instead of incrementing
//   jmp      in   jump request
//   cal_f    in   call qualifier (with jmp)
//   ret_f    in   return qualifier (with jmp)
//   rst_f    in   synchronous active-low soft reset
//   jmp_addr in   jump/call target
//   pc       out  registered program counter
//   stk_cnt  out  number of valid stack entries, 0..STACK_DEPTH
//   err_ovf  out  sticky call-on-full flag
//   err_unf  out  sticky return-on-empty flag

module program_counter #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           halt,
  input  logic                           jmp,
  input  logic                           cal_f,
  input  logic                           ret_f,
  input  logic                           rst_f,
  input  logic [CNTR_WIDTH-1:0]          jmp_addr,
  output logic [CNTR_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0]   stk_cnt,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;

  logic [CNTR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  push;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [CNTR_WIDTH-1:0] ret_addr;
  logic                  full;
  logic                  empty;

  // Indices use only the low bits of the count. At full (count == DEPTH) the
  // write index wraps to 0, overwriting the oldest entry. At empty the read
  // index wraps to DEPTH-1.
  assign wr_idx   = cnt_q[AW-1:0];
  assign rd_idx   = cnt_q[AW-1:0] - AW'(1);
  assign ret_addr = pc_q + CNTR_WIDTH'(1);
  assign full     = (cnt_q == CW'(STACK_DEPTH));
  assign empty    = (cnt_q == '0);

`ifdef STACK_GUARD_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
`endif

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
`ifdef STACK_GUARD_EN
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif
    if (!rst_f) begin
      // The soft reset leaves the error flags alone. Only rst clears them.
      pc_d  = '0;
      cnt_d = '0;
    end else if (jmp && cal_f) begin
`ifdef STACK_GUARD_EN
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push  = 1'b1;
        pc_d  = jmp_addr;
        cnt_d = cnt_q + CW'(1);
      end
`else
      push = 1'b1;
      pc_d = jmp_addr;
      if (!full) begin
        cnt_d = cnt_q + CW'(1);
      end
`endif
    end else if (jmp && ret_f) begin
`ifdef STACK_GUARD_EN
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = stack_q[rd_idx];
        cnt_d = cnt_q - CW'(1);
      end
`else
      pc_d = stack_q[rd_idx];
      if (!empty) begin
        cnt_d = cnt_q - CW'(1);
      end
`endif
    end else if (jmp) begin
      pc_d = jmp_addr;
    end else if (!halt) begin
      pc_d = pc_q + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef STACK_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

  // Stack storage is not reset. Entries above the count are don't-care.
  // The write is gated by rst so that a call overlapping reset is lost.
  always_ff @(posedge clk) begin
    if (push && rst) begin
      stack_q[wr_idx] <= ret_addr;
    end
  end

  assign pc      = pc_q;
  assign stk_cnt = cnt_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed table-driven bench for program_counter

module tb_program_counter;

  logic       clk;
  logic       rst;
  logic       halt;
  logic       jmp;
  logic       cal_f;
  logic       ret_f;
  logic       rst_f;
  logic [7:0] jmp_addr;
  logic [7:0] pc;
  logic [2:0] stk_cnt;
  logic       err_ovf;
  logic       err_unf;

  int errors = 0;
  int checks = 0;

  program_counter #(.CNTR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .jmp      (jmp),
    .cal_f    (cal_f),
    .ret_f    (ret_f),
    .rst_f    (rst_f),
    .jmp_addr (jmp_addr),
    .pc       (pc),
    .stk_cnt  (stk_cnt),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rf;
    logic       j;
    logic       c;
    logic       r;
    logic       h;
    logic [7:0] a;
    logic [7:0] epc;
    logic [2:0] ecnt;
    logic       eovf;
    logic       eunf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rf, logic j, logic c, logic r, logic h,
                              logic [7:0] a, logic [7:0] epc, logic [2:0] ecnt,
                              logic eovf, logic eunf);
    vec_t v;
    v.rf = rf; v.j = j; v.c = c; v.r = r; v.h = h; v.a = a;
    v.epc = epc; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] epc, input logic [2:0] ecnt,
                         input logic eovf, input logic eunf);
    chk({tag, ".pc"},  int'(pc),      int'(epc));
    chk({tag, ".cnt"}, int'(stk_cnt), int'(ecnt));
    chk({tag, ".ovf"}, int'(err_ovf), int'(eovf));
    chk({tag, ".unf"}, int'(err_unf), int'(eunf));
  endtask

  task automatic drive(input logic rf, input logic j, input logic c, input logic r,
                       input logic h, input logic [7:0] a);
    rst_f = rf; jmp = j; cal_f = c; ret_f = r; halt = h; jmp_addr = a;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state, no rising edge yet
    #3;
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Release mid-cycle; pc stays 0 until the first rising edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("release", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 8'(i), 3'd0, 1'b0, 1'b0);
    end

    //          rf    j     c     r     h     addr   pc     cnt  ovf   unf
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h10, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h41, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h42, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h43, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h20, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h82, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h30, 8'h30, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 8'h50, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 8'hA0, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 8'hA1, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA2, 8'hA2, 3'd3, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA3, 8'hA3, 3'd4, 1'b0, 1'b0));
`ifdef STACK_GUARD_EN
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB0, 8'hA3, 3'd4, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 3'd3, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 3'd0, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1));
`else
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB0, 8'hB0, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 3'd3, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA2, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 3'd1, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA4, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA3, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0));
`endif

    foreach (vq[i]) begin
      drive(vq[i].rf, vq[i].j, vq[i].c, vq[i].r, vq[i].h, vq[i].a);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].epc, vq[i].ecnt, vq[i].eovf, vq[i].eunf);
    end

    // Asynchronous reset mid-cycle clears everything without a rising edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    chk("pre_async.pc", int'(pc), 32'h02);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    step();
    chk_all("after_async", 8'h01, 3'd0, 1'b0, 1'b0);

    // A call overlapping reset is discarded, and pc=0 is held until the first edge after release
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    #2;
    rst = 1'b0;
    step();
    chk_all("rst_call", 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk_all("rst_call_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk_all("rst_call_run", 8'h01, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule
